// File: rtl/gs_div_arbiter.sv
// Round-robin front-end sharing one gs_div; optional WAIT abort counter under GS_DIV_ARB_TIMEOUT_EN.
// Response >= 4 cycles after grant (1 cycle for divide-by-zero); one job in flight, req_ready low until rsp handshake.
module gs_div_arbiter #(
   parameter int  NUM_REQ = 4,
   parameter int  T_BITS  = 72,
   parameter int  TIMEOUT = 31,
   localparam int ID_BITS = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*T_BITS-1:0] req_n,
   input  logic [NUM_REQ*T_BITS-1:0] req_d,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_BITS-1:0]        rsp_id,
   output logic [T_BITS-1:0]         rsp_q,
   output logic                      rsp_err,
   output logic                      div_rst,
   output logic [T_BITS-1:0]         div_n,
   output logic [T_BITS-1:0]         div_d,
   input  logic [T_BITS-1:0]         div_q,
   input  logic                      div_done
);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t             state;
   logic [ID_BITS-1:0] ptr;
   logic [ID_BITS-1:0] win_id;
   logic [ID_BITS-1:0] idx;
   logic               win_vld;
   logic               settle;
   logic [T_BITS-1:0]  sel_n;
   logic [T_BITS-1:0]  sel_d;

`ifdef GS_DIV_ARB_TIMEOUT_EN
   localparam int CNT_BITS = $clog2(TIMEOUT + 1);
   logic [CNT_BITS-1:0] wcnt;
`endif

   // First valid requester at or after the pointer wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_BITS'((int'(ptr) + k) % NUM_REQ);
         if (!win_vld && req_valid[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
   end

   assign req_ready = (state == IDLE && !rst && win_vld) ? (NUM_REQ'(1) << win_id) : '0;
   assign sel_n     = req_n[int'(win_id)*T_BITS +: T_BITS];
   assign sel_d     = req_d[int'(win_id)*T_BITS +: T_BITS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         settle    <= 1'b0;
         div_rst   <= 1'b1;
         div_n     <= '0;
         div_d     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_q     <= '0;
         rsp_err   <= 1'b0;
`ifdef GS_DIV_ARB_TIMEOUT_EN
         wcnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               div_rst <= 1'b1;
               if (win_vld) begin
                  ptr    <= ID_BITS'((int'(win_id) + 1) % NUM_REQ);
                  rsp_id <= win_id;
                  if (sel_d == '0) begin
                     // Divider stays parked; answer immediately with saturated error.
                     rsp_q     <= '1;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     div_n <= sel_n;
                     div_d <= sel_d;
                     state <= START;
                  end
               end
            end
            START: begin
               div_rst <= 1'b0;
               settle  <= 1'b1;
               state   <= WAIT;
`ifdef GS_DIV_ARB_TIMEOUT_EN
               wcnt    <= CNT_BITS'(1);
`endif
            end
            WAIT: begin
               settle <= 1'b0;
               if (div_done && !settle) begin
                  rsp_q     <= div_q;
                  rsp_err   <= 1'b0;
                  div_rst   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
`ifdef GS_DIV_ARB_TIMEOUT_EN
               else if (wcnt == CNT_BITS'(TIMEOUT)) begin
                  rsp_q     <= '1;
                  rsp_err   <= 1'b1;
                  div_rst   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gs_div_arbiter.sv
// Directed bench for gs_div_arbiter with a behavioural divider model (done after a programmable latency).
module tb_gs_div_arbiter;

   localparam int NR = 4;
   localparam int TB = 72;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*TB-1:0] req_n;
   logic [NR*TB-1:0] req_d;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_id;
   logic [TB-1:0]    rsp_q;
   logic             rsp_err;
   logic             div_rst;
   logic [TB-1:0]    div_n;
   logic [TB-1:0]    div_d;
   logic [TB-1:0]    div_q;
   logic             div_done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int lat;
   int prev_cyc;
   int bad;
   int model_lat;
   int mcnt;
   int exp_id [6] = '{0, 1, 2, 3, 1, 3};
   logic [TB-1:0]  ones = '1;
   logic [143:0]   dsafe;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gs_div_arbiter #(.NUM_REQ(NR), .T_BITS(TB), .TIMEOUT(31)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_d(req_d),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err),
      .div_rst(div_rst), .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_done(div_done)
   );

   // Divider model: counts cycles out of reset, done once the count reaches model_lat; Q = N/D in 32.40.
   always @(posedge clk or posedge rst) begin
      if (rst || div_rst) mcnt <= 0;
      else                mcnt <= mcnt + 1;
   end
   assign div_done = !div_rst && (mcnt >= model_lat);
   assign dsafe    = (div_d == '0) ? 144'd1 : {72'd0, div_d};
   assign div_q    = 72'(({72'd0, div_n} << 40) / dsafe);

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [TB-1:0] n, input logic [TB-1:0] d);
      req_n[i*TB +: TB] = n;
      req_d[i*TB +: TB] = d;
   endtask

   // Step negedges until rsp_valid or the budget runs out; lat counts cycles.
   task automatic wait_rsp(input int limit);
      while (!rsp_valid && lat < limit) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_arrived", rsp_valid, 1);
   endtask

   initial begin
      req_valid = '0;
      req_n     = '0;
      req_d     = '0;
      rsp_ready = 1'b0;
      model_lat = 0;
      bad       = 0;
      #1 rst = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_div_rst",   div_rst,   1);
      chk("rst_div_n",     div_n,     0);
      chk("rst_div_d",     div_d,     0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id",    rsp_id,    0);
      chk("rst_rsp_q",     rsp_q,     0);
      chk("rst_rsp_err",   rsp_err,   0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Round robin: all four, then only 1 and 3.
      for (int i = 0; i < NR; i++) set_req(i, 72'(10 + i) << 40, 72'd1 << 40);
      rsp_ready = 1'b1;
      #1;
      chk("rr_first_grant", req_ready, 4'b0001);
      prev_cyc = 0;
      for (int j = 0; j < 6; j++) begin
         lat = 0;
         wait_rsp(60);
         chk("rr_id", rsp_id, exp_id[j]);
         chk("rr_q",  rsp_q,  72'(10 + exp_id[j]) << 40);
         chk("rr_err", rsp_err, 0);
         if (j > 0) chk("rr_spacing", cyc - prev_cyc, 5);
         prev_cyc = cyc;
         if (j == 3) req_valid = 4'b1010;
         if (j == 5) req_valid = 4'b0000;
         @(negedge clk);
      end

      // Single request 6.0/2.0 with 9-cycle divider, then 5 cycles of backpressure.
      rsp_ready = 1'b0;
      model_lat = 9;
      set_req(0, 72'd6 << 40, 72'd2 << 40);
      req_valid = 4'b0001;
      #1;
      chk("single_grant", req_ready, 4'b0001);
      @(negedge clk);
      lat = 1;
      req_valid = '0;
      chk("start_div_rst", div_rst, 1);
      chk("start_div_n",   div_n,   72'd6 << 40);
      chk("start_div_d",   div_d,   72'd2 << 40);
      @(negedge clk);
      lat = 2;
      chk("settle_div_rst", div_rst, 0);
      wait_rsp(100);
      chk("single_lat", lat, 12);
      chk("single_id",  rsp_id, 0);
      chk("single_q",   rsp_q,  72'd3 << 40);
      chk("single_err", rsp_err, 0);
      req_valid = 4'hF;
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_id",    rsp_id,    0);
         chk("bp_q",     rsp_q,     72'd3 << 40);
         chk("bp_ready", req_ready, 0);
         @(negedge clk);
      end
      chk("bp_valid6", rsp_valid, 1);
      rsp_ready = 1'b1;
      req_valid = '0;
      @(negedge clk);
      chk("bp_release", rsp_valid, 0);

      // Divide-by-zero from requester 2 (pointer now at 1).
      model_lat = 0;
      rsp_ready = 1'b0;
      set_req(2, 72'd5 << 40, '0);
      req_valid = 4'b0100;
      #1;
      chk("dz_grant", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = '0;
      chk("dz_valid", rsp_valid, 1);
      chk("dz_err",   rsp_err,   1);
      chk("dz_q",     rsp_q,     ones);
      chk("dz_id",    rsp_id,    2);
      chk("dz_rst",   div_rst,   1);
      @(negedge clk);
      chk("dz_rst_hold", div_rst, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("dz_release", rsp_valid, 0);
      chk("dz_rst_end", div_rst,   1);

      // Hung divider on requester 3.
      rsp_ready = 1'b0;
      model_lat = 1000000;
      set_req(3, 72'd1 << 40, 72'd3 << 40);
      req_valid = 4'b1000;
      @(negedge clk);
      lat = 1;
      req_valid = '0;
`ifdef GS_DIV_ARB_TIMEOUT_EN
      wait_rsp(100);
      chk("to_lat", lat, 33);
      chk("to_err", rsp_err, 1);
      chk("to_q",   rsp_q,   ones);
      chk("to_id",  rsp_id,  3);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("to_release", rsp_valid, 0);
      rsp_ready = 1'b0;
      req_valid = 4'b1000;
      @(negedge clk);
      req_valid = '0;
      repeat (5) @(negedge clk);
`else
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rsp_valid || div_rst) bad++;
      end
      chk("hang_wait", bad, 0);
`endif

      // Asynchronous reset in the middle of WAIT.
      chk("mid_wait_pre", div_rst, 0);
      req_valid = 4'hF;
      #2 rst = 1'b1;
      #1;
      chk("arst_div_rst",   div_rst,   1);
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_req_ready", req_ready, 0);
      chk("arst_div_n",     div_n,     0);
      @(negedge clk);
      rst = 1'b0;
      model_lat = 0;
      rsp_ready = 1'b1;
      #1;
      chk("post_rst_grant", req_ready, 4'b0001);
      @(negedge clk);
      lat = 1;
      req_valid = '0;
      wait_rsp(20);
      chk("post_rst_id",  rsp_id, 0);
      chk("post_rst_lat", lat,    4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
